// File: rtl/sram_ctrl_ws.sv
// Async-SRAM controller with programmable read/write wait states, byte masks and
// registered strobes. Define SRAM_RDATA_REG_EN to register read data in an input flop.
module sram_ctrl_ws #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  inout  wire  [DATA_W-1:0]   ram_data,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_be_n,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);
  localparam logic [3:0] WR_WAIT_C = 4'(WR_WAIT);

  typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [BE_W-1:0]     mask_reg, mask_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                resp_valid_reg, resp_valid_next;
  logic                ready_reg, ready_next;
  logic                ce_n_reg, ce_n_next;
  logic                oe_n_reg, oe_n_next;
  logic                we_n_reg, we_n_next;
  logic [BE_W-1:0]     be_n_reg, be_n_next;
  logic                drive_reg, drive_next;

`ifdef SRAM_RDATA_REG_EN
  // Input flop kept free of reset/enable so it can pack into the I/O cell.
  logic [DATA_W-1:0]   din_reg;
  logic                tail_reg, tail_next;

  always_ff @(posedge clk) begin
    din_reg <= ram_data;
  end
`endif

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    mask_next       = mask_reg;
    rdata_next      = rdata_reg;
    resp_valid_next = 1'b0;
`ifdef SRAM_RDATA_REG_EN
    tail_next       = tail_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req_valid && ready_reg) begin
          addr_next  = req_addr;
          wdata_next = req_wdata;
          mask_next  = req_wmask;
          if (!req_we) begin
            state_next = RD;
            cnt_next   = RD_WAIT_C;
          end else if (req_wmask != '0) begin
            state_next = WSETUP;
          end else begin
            resp_valid_next = 1'b1;
          end
        end
      end
      RD: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
`ifdef SRAM_RDATA_REG_EN
          // One extra cycle with oe_n low while the input flop's value is copied out.
          if (!tail_reg) begin
            tail_next = 1'b1;
          end else begin
            tail_next       = 1'b0;
            state_next      = IDLE;
            resp_valid_next = 1'b1;
            rdata_next      = din_reg;
          end
`else
          state_next      = IDLE;
          resp_valid_next = 1'b1;
          rdata_next      = ram_data;
`endif
        end
      end
      WSETUP: begin
        state_next = WPULSE;
        cnt_next   = WR_WAIT_C;
      end
      WPULSE: begin
        if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
        else state_next = WHOLD;
      end
      WHOLD: begin
        state_next      = IDLE;
        resp_valid_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Pin values are decoded from the next state so every strobe leaves a flop.
    ready_next = (state_next == IDLE);
    ce_n_next  = (state_next == IDLE);
    oe_n_next  = (state_next != RD);
    we_n_next  = (state_next != WPULSE);
    drive_next = (state_next == WSETUP) || (state_next == WPULSE) || (state_next == WHOLD);
    be_n_next  = drive_next ? ~mask_next : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mask_reg       <= '0;
      rdata_reg      <= '0;
      resp_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
      ce_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
      we_n_reg       <= 1'b1;
      be_n_reg       <= '0;
      drive_reg      <= 1'b0;
`ifdef SRAM_RDATA_REG_EN
      tail_reg       <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      mask_reg       <= mask_next;
      rdata_reg      <= rdata_next;
      resp_valid_reg <= resp_valid_next;
      ready_reg      <= ready_next;
      ce_n_reg       <= ce_n_next;
      oe_n_reg       <= oe_n_next;
      we_n_reg       <= we_n_next;
      be_n_reg       <= be_n_next;
      drive_reg      <= drive_next;
`ifdef SRAM_RDATA_REG_EN
      tail_reg       <= tail_next;
`endif
    end
  end

  assign req_ready  = ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = rdata_reg;
  assign ram_addr   = addr_reg;
  assign ram_be_n   = be_n_reg;
  assign ram_ce_n   = ce_n_reg;
  assign ram_oe_n   = oe_n_reg;
  assign ram_we_n   = we_n_reg;
  assign ram_data   = drive_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_ws.sv
// Bench for sram_ctrl_ws: async SRAM device model, request-level scoreboard and
// directed vectors with hand-computed latencies and data.
`timescale 1ns/1ps
module tb_sram_ctrl_ws;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
`ifdef SRAM_RDATA_REG_EN
  localparam int RD_LAT = 4;
  localparam int OE_CYC = 3;
`else
  localparam int RD_LAT = 3;
  localparam int OE_CYC = 2;
`endif
  localparam int WR_LAT = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [3:0]        req_wmask = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  wire  [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be_n;
  logic              ram_ce_n, ram_oe_n, ram_we_n;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 0;

  logic [31:0] sram    [0:255];
  logic [31:0] ref_mem [0:255];

  typedef struct {
    int         due;
    bit         is_rd;
    logic [7:0] a;
    logic [31:0] d;
    logic [3:0] m;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  logic exp_v;

  int oe_low, we_low, ce_low;
  logic [3:0] be_seen;

  always #5 clk = ~clk;

  sram_ctrl_ws #(.DATA_W(32), .ADDR_W(20), .RD_WAIT(1), .WR_WAIT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Asynchronous SRAM device.
  assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? sram[ram_addr[7:0]] : 32'bz;
  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n)
      sram[ram_addr[7:0]] <= merge(sram[ram_addr[7:0]], ram_data, ~ram_be_n);
  end

  // Request-level model: each accepted request owes one response after a fixed latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) q.delete();
    else if (req_valid && req_ready) begin
      if (!req_we) q.push_back('{cyc + RD_LAT, 1'b1, req_addr[7:0], 32'h0, 4'h0});
      else if (req_wmask == 4'h0) q.push_back('{cyc + 1, 1'b0, req_addr[7:0], req_wdata, 4'h0});
      else q.push_back('{cyc + WR_LAT, 1'b0, req_addr[7:0], req_wdata, req_wmask});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_v = 1'b1;
        cur = q.pop_front();
      end
      vectors++;
      if (resp_valid !== exp_v) begin
        miscompares++;
        $display("FAIL resp_valid@%0d: got %b, want %b", cyc, resp_valid, exp_v);
      end
      if (exp_v) begin
        if (cur.is_rd) begin
          vectors++;
          if (resp_rdata !== ref_mem[cur.a]) begin
            miscompares++;
            $display("FAIL model_rdata@%0d: got %h, want %h", cyc, resp_rdata, ref_mem[cur.a]);
          end
        end else begin
          ref_mem[cur.a] = merge(ref_mem[cur.a], cur.d, cur.m);
        end
      end
      vectors++;
      if (dut.drive_reg && !ram_oe_n) begin
        miscompares++;
        $display("FAIL turnaround@%0d: got drive=1 oe_n=0, want no overlap", cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!ram_oe_n) oe_low++;
    if (!ram_ce_n) ce_low++;
    if (!ram_we_n) begin
      we_low++;
      be_seen = ram_be_n;
    end
  end

  task automatic clr();
    oe_low = 0; we_low = 0; ce_low = 0; be_seen = 4'hF;
  endtask

  task automatic send(input logic we, input logic [19:0] a, input logic [31:0] d,
                      input logic [3:0] m, input bit keep, output int t);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (req_ready) begin
        t = cyc;
        break;
      end
    end
    #1;
    if (!keep) req_valid = 1'b0;
    if (t < 0) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got no accept, want accept within 40 cycles");
    end
  endtask

  task automatic wait_resp(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: got no resp_valid, want one within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tr, t1, t2;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 32'hA5A50000 | i;
      ref_mem[i] = 32'hA5A50000 | i;
    end
    sram[8'h12] = 32'hDEADBEEF; ref_mem[8'h12] = 32'hDEADBEEF;
    sram[8'h34] = 32'h11223344; ref_mem[8'h34] = 32'h11223344;

    // 1. reset
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_ce_n", 32'(ram_ce_n), 32'h1);
    check("rst_oe_n", 32'(ram_oe_n), 32'h1);
    check("rst_we_n", 32'(ram_we_n), 32'h1);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_be_n", 32'(ram_be_n), 32'h0);
    check("rst_addr", 32'(ram_addr), 32'h0);
    check("rst_hiz", 32'(dut.drive_reg), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'h1);
    @(posedge clk); #1;

    // 2. read
    clr();
    send(1'b0, 20'h00012, 32'h0, 4'h0, 1'b0, t);
    wait_resp(tr);
    check("rd_latency", 32'(tr - t), 32'(RD_LAT));
    check("rd_oe_cycles", 32'(oe_low), 32'(OE_CYC));
    check("rd_data", resp_rdata, 32'hDEADBEEF);

    // 3. masked write then readback
    clr();
    send(1'b1, 20'h00034, 32'h00AB0000, 4'b0100, 1'b0, t);
    wait_resp(tr);
    check("wr_latency", 32'(tr - t), 32'd5);
    check("wr_be_n", 32'(be_seen), 32'h0000000B);
    check("wr_we_cycles", 32'(we_low), 32'd2);
    check("wr_rdata_held", resp_rdata, 32'hDEADBEEF);
    send(1'b0, 20'h00034, 32'h0, 4'h0, 1'b0, t);
    wait_resp(tr);
    check("wr_readback", resp_rdata, 32'h11AB3344);

    // 4. empty-mask write
    clr();
    send(1'b1, 20'h00034, 32'hFFFFFFFF, 4'b0000, 1'b0, t);
    wait_resp(tr);
    check("nomask_latency", 32'(tr - t), 32'd1);
    check("nomask_ce_cycles", 32'(ce_low), 32'd0);
    send(1'b0, 20'h00034, 32'h0, 4'h0, 1'b0, t);
    wait_resp(tr);
    check("nomask_readback", resp_rdata, 32'h11AB3344);

    // 5. back-to-back write then read, valid held high
    send(1'b1, 20'h00040, 32'hCAFEF00D, 4'b1111, 1'b1, t1);
    send(1'b0, 20'h00040, 32'h0, 4'h0, 1'b0, t2);
    check("b2b_accept_gap", 32'(t2 - t1), 32'd5);
    wait_resp(tr);
    check("b2b_rd_latency", 32'(tr - t2), 32'(RD_LAT));
    check("b2b_rdata", resp_rdata, 32'hCAFEF00D);

    // 6. reset during the write pulse
    send(1'b1, 20'h00056, 32'h12345678, 4'b1111, 1'b0, t);
    t1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ram_we_n) begin
        t1 = cyc;
        break;
      end
    end
    check("abort_saw_wpulse", 32'(t1 >= 0), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_we_n", 32'(ram_we_n), 32'h1);
    check("abort_ce_n", 32'(ram_ce_n), 32'h1);
    check("abort_hiz", 32'(dut.drive_reg), 32'h0);
    check("abort_no_resp", 32'(resp_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 6; i++) @(negedge clk);
    @(posedge clk); #1;
    send(1'b0, 20'h00012, 32'h0, 4'h0, 1'b0, t);
    wait_resp(tr);
    check("post_abort_rdata", resp_rdata, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
